// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues ibus requests, holds one instruction for decode,
// drops wrong-path data after redirects. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_ctrl #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        stall,
   output logic        out_valid,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr,
   output logic [1:0]  dbg_state
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [63:0] perf_fetch_cnt,
   output logic [63:0] perf_wait_cnt
`endif
);

   // Handshake: a request is live while ireq_valid=1; its address must not move until the
   // cycle iresp_data_ok=1, which completes it. Decode takes out_* on any edge with out_valid && !stall.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [63:0] pc;
   logic [63:0] drop_addr;
   logic [63:0] target;

   assign target    = {redirect_pc[63:2], 2'b00};
   assign dbg_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE: state_nxt = S_REQ;
         S_REQ: begin
            if (redirect_valid)     state_nxt = iresp_data_ok ? S_REQ : S_DROP;
            else if (iresp_data_ok) state_nxt = S_HOLD;
            else                    state_nxt = S_REQ;
         end
         S_HOLD: state_nxt = (redirect_valid || !stall) ? S_REQ : S_HOLD;
         S_DROP: state_nxt = iresp_data_ok ? S_REQ : S_DROP;
         default: state_nxt = S_IDLE;
      endcase
   end

   // While dropping, the bus still sees the abandoned address until it completes.
   always_comb begin
      ireq_valid = (state == S_REQ) || (state == S_DROP);
      ireq_addr  = (state == S_DROP) ? drop_addr : pc;
      out_valid  = (state == S_HOLD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= RESET_PC;
         drop_addr <= RESET_PC;
         out_pc    <= 64'd0;
         out_instr <= 32'd0;
      end else begin
         if (redirect_valid) pc <= target;
         if (state == S_REQ) begin
            if (redirect_valid) begin
               if (!iresp_data_ok) drop_addr <= pc;
            end else if (iresp_data_ok) begin
               out_instr <= iresp_data;
               out_pc    <= pc;
               pc        <= pc + 64'd4;
            end
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetch_cnt <= 64'd0;
         perf_wait_cnt  <= 64'd0;
      end else begin
         if ((state == S_HOLD) && !stall && !redirect_valid)
            perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
         if (((state == S_REQ) || (state == S_DROP)) && !iresp_data_ok)
            perf_wait_cnt <= perf_wait_cnt + 64'd1;
      end
   end
`endif

endmodule
